// File: rtl/tone_pkg.sv
// Shared widths, amplitude step, note half-period table and the sample helper for the tone synthesizer.
// Latency: none (declarations and a pure function).
// Backpressure: none.
package tone_pkg;

    localparam int DIV_W    = 9;
    localparam int NOTE_W   = 22;
    localparam int SAMPLE_W = 16;

    localparam logic [SAMPLE_W-1:0] AMP_STEP = 16'h1000;

    // Half-periods in 100 MHz cycles (50e6 / f), low octave La up to high octave Si
    localparam logic [NOTE_W-1:0] NOTE_LO_LA = 22'd227272;
    localparam logic [NOTE_W-1:0] NOTE_LO_SI = 22'd202429;
    localparam logic [NOTE_W-1:0] NOTE_DO    = 22'd190840;
    localparam logic [NOTE_W-1:0] NOTE_RE    = 22'd170068;
    localparam logic [NOTE_W-1:0] NOTE_MI    = 22'd151515;
    localparam logic [NOTE_W-1:0] NOTE_FA    = 22'd143266;
    localparam logic [NOTE_W-1:0] NOTE_SO    = 22'd127551;
    localparam logic [NOTE_W-1:0] NOTE_LA    = 22'd113636;
    localparam logic [NOTE_W-1:0] NOTE_SI    = 22'd101215;
    localparam logic [NOTE_W-1:0] NOTE_HI_DO = 22'd95420;
    localparam logic [NOTE_W-1:0] NOTE_HI_RE = 22'd85034;
    localparam logic [NOTE_W-1:0] NOTE_HI_MI = 22'd75758;
    localparam logic [NOTE_W-1:0] NOTE_HI_FA = 22'd71633;
    localparam logic [NOTE_W-1:0] NOTE_HI_SO = 22'd63776;
    localparam logic [NOTE_W-1:0] NOTE_HI_LA = 22'd56818;
    localparam logic [NOTE_W-1:0] NOTE_HI_SI = 22'd50607;

    // Square-wave sample: +amp on the high half, two's-complement -amp on the low half, zero when quiet
    function automatic logic [SAMPLE_W-1:0] tone_sample(
        input logic       sq,
        input logic [2:0] volume,
        input logic       quiet
    );
        logic [SAMPLE_W-1:0] amp;
        amp = {1'b0, volume, 12'h000};
        if (quiet || (volume == 3'd0)) begin
            return '0;
        end
        return sq ? amp : (~amp + 1'b1);
    endfunction

endpackage

// File: rtl/tone_synth_if.sv
// Control inputs and I2S pins of the tone synthesizer bundled as one port.
// Latency: none (wires only).
// Backpressure: none; the audio pins run continuously.
interface tone_synth_if;
    import tone_pkg::*;

    logic [NOTE_W-1:0] note_div;
    logic [2:0]        volume;
    logic              mute;
    logic              audio_mclk;
    logic              audio_lrck;
    logic              audio_sck;
    logic              audio_sdin;

    // Controller side: sets the note and listens to the pins
    modport master (
        output note_div, volume, mute,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin
    );

    // Synthesizer side
    modport slave (
        input  note_div, volume, mute,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin
    );
endinterface

// File: rtl/i2s_serializer.sv
// Divides clk into mclk/sck/lrck and shifts a 16-bit left-justified stereo word out MSB first.
// Latency: sample captured at div_cnt==511, its MSB appears on sdin at div_cnt==0 (1 clk).
// Backpressure: none; samples are taken once per 512-cycle frame whatever the source does.
module i2s_serializer
    import tone_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin
);

    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [SAMPLE_W-1:0] snap_l_q, snap_l_d;
    logic [SAMPLE_W-1:0] snap_r_q, snap_r_d;
    logic                mclk_q, mclk_d;
    logic                lrck_q, lrck_d;
    logic                sck_q, sck_d;
    logic                sdin_q, sdin_d;
    logic [SAMPLE_W-1:0] word;
    logic [3:0]          bit_idx;

    // Next-state: clocks are registered copies of the next counter value so each pin equals
    // its div_cnt bit in the same cycle; sdin looks ahead the same way so it flips on sck fall.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        snap_l_d  = snap_l_q;
        snap_r_d  = snap_r_q;
        if (div_cnt_q == {DIV_W{1'b1}}) begin
            snap_l_d = sample_l;
            snap_r_d = sample_r;
        end
        word    = div_cnt_d[8] ? snap_r_d : snap_l_d;
        bit_idx = 4'd15 - div_cnt_d[7:4];
        sdin_d  = word[bit_idx];
        mclk_d  = div_cnt_d[1];
        sck_d   = div_cnt_d[3];
        lrck_d  = div_cnt_d[8];
    end

    // State register; reset parks every pin low and restarts the frame at div_cnt=0
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            snap_l_q  <= '0;
            snap_r_q  <= '0;
            mclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            sck_q     <= 1'b0;
            sdin_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            snap_l_q  <= snap_l_d;
            snap_r_q  <= snap_r_d;
            mclk_q    <= mclk_d;
            lrck_q    <= lrck_d;
            sck_q     <= sck_d;
            sdin_q    <= sdin_d;
        end
    end

    assign audio_mclk = mclk_q;
    assign audio_lrck = lrck_q;
    assign audio_sck  = sck_q;
    assign audio_sdin = sdin_q;

endmodule

// File: rtl/tone_synth.sv
// Square-wave tone generator with 3-bit volume and mute, feeding an I2S serializer.
// Latency: note change reaches sq within note_div+1 clk, then up to 512 clk to the serial frame.
// Backpressure: none; inputs are sampled freely, frames in flight are never altered.
module tone_synth
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
)(
    input  logic         clk,
    input  logic         rst,
    tone_synth_if.slave  bus
);

    logic [NOTE_W-1:0]   tone_cnt_q, tone_cnt_d;
    logic                sq_q, sq_d;
    logic                silent;
    logic [SAMPLE_W-1:0] sample;

    // Tone counter: >= compare lets a shortened note_div wrap immediately instead of running to 2^22
    always_comb begin
        silent     = (bus.note_div < 22'd2);
        tone_cnt_d = tone_cnt_q + 1'b1;
        sq_d       = sq_q;
        if (silent) begin
            tone_cnt_d = '0;
            sq_d       = 1'b0;
        end else if (tone_cnt_q >= (bus.note_div - 1'b1)) begin
            tone_cnt_d = '0;
            sq_d       = ~sq_q;
        end
    end

    // Sample selection; both channels carry the same word
    always_comb begin
        sample = tone_sample(sq_q, bus.volume, bus.mute | silent);
    end

    // Tone state register
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_q <= '0;
            sq_q       <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            sq_q       <= sq_d;
        end
    end

    i2s_serializer u_ser (
        .clk        (clk),
        .rst        (rst),
        .sample_l   (sample),
        .sample_r   (sample),
        .audio_mclk (bus.audio_mclk),
        .audio_lrck (bus.audio_lrck),
        .audio_sck  (bus.audio_sck),
        .audio_sdin (bus.audio_sdin)
    );

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth: reset state, tone timing, serial frames, silence paths, mid-frame reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_tone_synth;
    import tone_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    tone_synth_if bus ();

    tone_synth #(.CLK_HZ(100_000_000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled on the falling edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_start(input bit skip);
        int n;
        n = 0;
        if (skip) step(1);
        while ((dut.u_ser.div_cnt_q != 9'd0) && (n < 1024)) begin
            step(1);
            n++;
        end
        check("frame_start", {23'd0, dut.u_ser.div_cnt_q}, 32'd0);
    endtask

    // Checks the 512 cycles of one frame starting at div_cnt==0: clock pins and every sdin bit
    task automatic check_frame(input string tag, input logic [15:0] word);
        logic [8:0] p;
        int         idx;
        for (int j = 0; j < 512; j++) begin
            p   = j[8:0];
            idx = 15 - int'(p[7:4]);
            check({tag, "_clk"}, {29'd0, bus.audio_lrck, bus.audio_sck, bus.audio_mclk},
                  {29'd0, p[8], p[3], p[1]});
            check({tag, "_sdin"}, {31'd0, bus.audio_sdin}, {31'd0, word[idx]});
            step(1);
        end
    endtask

    initial begin
        // ---- power-up reset, 4 cycles, all pins must sit at 0 ----
        rst          = 1'b1;
        bus.note_div = 22'd0;
        bus.volume   = 3'd0;
        bus.mute     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_pins", {28'd0, bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin}, 32'd0);
            check("rst_div", {23'd0, dut.u_ser.div_cnt_q}, 32'd0);
        end
        check("rst_tone", {10'd0, dut.tone_cnt_q}, 32'd0);
        check("rst_sq", {31'd0, dut.sq_q}, 32'd0);

        // ---- release: note_div=100, vol=7; frame 0 zero, frame 1 sq=1 (+7000), frame 2 sq=0 (9000) ----
        rst          = 1'b0;
        bus.note_div = 22'd100;
        bus.volume   = 3'd7;
        wait_start(1'b0);
        check_frame("f0_zero", 16'h0000);
        check_frame("f1_pos7", 16'h7000);
        check_frame("f2_neg7", 16'h9000);

        // ---- tone timing and shortened note_div wrap ----
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        cyc = 0;
        check("t0_tone", {10'd0, dut.tone_cnt_q}, 32'd0);
        check("t0_sq", {31'd0, dut.sq_q}, 32'd0);
        step(99);
        check("t99_tone", {10'd0, dut.tone_cnt_q}, 32'd99);
        check("t99_sq", {31'd0, dut.sq_q}, 32'd0);
        step(1);
        check("t100_tone", {10'd0, dut.tone_cnt_q}, 32'd0);
        check("t100_sq", {31'd0, dut.sq_q}, 32'd1);
        step(99);
        check("t199_sq", {31'd0, dut.sq_q}, 32'd1);
        step(1);
        check("t200_sq", {31'd0, dut.sq_q}, 32'd0);
        step(50);
        check("t250_tone", {10'd0, dut.tone_cnt_q}, 32'd50);
        bus.note_div = 22'd40;
        step(1);
        check("t251_tone", {10'd0, dut.tone_cnt_q}, 32'd0);
        check("t251_sq", {31'd0, dut.sq_q}, 32'd1);
        step(39);
        check("t290_tone", {10'd0, dut.tone_cnt_q}, 32'd39);
        check("t290_sq", {31'd0, dut.sq_q}, 32'd1);
        step(1);
        check("t291_sq", {31'd0, dut.sq_q}, 32'd0);
        step(40);
        check("t331_sq", {31'd0, dut.sq_q}, 32'd1);
        bus.volume = 3'd6;

        // ---- reset at div_cnt=300 of a frame carrying +6000 (bit 13 set) ----
        step(812 - 331);
        check("d300_div", {23'd0, dut.u_ser.div_cnt_q}, 32'd300);
        check("d300_sdin", {31'd0, bus.audio_sdin}, 32'd1);
        rst = 1'b1;
        step(1);
        check("midrst_pins", {28'd0, bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin}, 32'd0);
        check("midrst_div", {23'd0, dut.u_ser.div_cnt_q}, 32'd0);
        check("midrst_sq", {31'd0, dut.sq_q}, 32'd0);
        rst = 1'b0;
        wait_start(1'b0);
        check_frame("midrst_frame", 16'h0000);

        // ---- silence paths: mute, note_div=1, volume=0 ----
        bus.mute = 1'b1;
        wait_start(1'b1);
        check_frame("mute", 16'h0000);
        bus.mute     = 1'b0;
        bus.note_div = 22'd1;
        step(2);
        check("nd1_tone", {10'd0, dut.tone_cnt_q}, 32'd0);
        check("nd1_sq", {31'd0, dut.sq_q}, 32'd0);
        wait_start(1'b1);
        check_frame("nd1", 16'h0000);
        // sq restarts low and stays low for 5000 cycles, covering the next two frames checked
        bus.note_div = 22'd5000;
        bus.volume   = 3'd0;
        wait_start(1'b1);
        check_frame("vol0", 16'h0000);
        bus.volume = 3'd3;
        wait_start(1'b1);
        check_frame("vol3_neg", 16'hD000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency; informational, no logic depends on it.
REQ-002 clk  input  1  system clock, 100 MHz, all logic on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 note_div  input  22  half-period of tone in clk cycles; values 0 and 1 mean silence.
REQ-005 volume  input  3  amplitude select, 0 = silent, 7 = loudest.
REQ-006 mute  input  1  forces zero sample while high.
REQ-007 audio_mclk  output  1  master clock, clk/4.
REQ-008 audio_lrck  output  1  channel select, clk/512; 0 = left, 1 = right.
REQ-009 audio_sck  output  1  serial bit clock, clk/16.
REQ-010 audio_sdin  output  1  serial sample data, MSB first.

Function
REQ-011 A 9-bit free-running counter div_cnt SHALL increment every cycle and wrap 511->0.
REQ-012 audio_mclk SHALL equal div_cnt[1], audio_sck div_cnt[3], audio_lrck div_cnt[8], all driven from registers.
REQ-013 A 22-bit tone_cnt SHALL increment each cycle; when tone_cnt >= note_div-1, it SHALL clear to 0 and toggle square bit sq.
REQ-014 Compare SHALL use >= so a note_div decrease below the current tone_cnt wraps on the next cycle, with no 2^22 overrun.
REQ-015 note_div of 0 or 1 SHALL hold tone_cnt and sq at 0 and force a zero sample.
REQ-016 Amplitude SHALL be amp = volume * 16'h1000 (vol 7 -> 16'h7000).
REQ-017 Sample SHALL be +amp when sq=1 and -amp (two's complement) when sq=0.
REQ-018 Sample SHALL be 16'h0000 when volume=0, mute=1, or silence applies.
REQ-019 Left and right samples SHALL be identical.
REQ-020 Sample SHALL be snapshotted into the serializer only in the cycle div_cnt==511; the first bit is presented at div_cnt==0.
REQ-021 Format SHALL be left-justified, 16 bits per channel with no extra delay bit.
REQ-022 During div_cnt[7:4]=k, audio_sdin SHALL carry bit 15-k of the left word when lrck=0 and of the right word when lrck=1.
REQ-023 audio_sdin SHALL change only when div_cnt[3:0]==0 (sck falling edge) and hold for 16 clk.
REQ-024 Input changes SHALL take effect on the sample at the next snapshot; a frame in flight is never altered.
REQ-025 Latency from note_div change to first audible edge SHALL be at most note_div+1 cycles for tone timing plus at most 512 cycles to the serial frame.

Reset
REQ-026 Under rst, div_cnt, tone_cnt, sq, snapshot registers, audio_mclk, audio_lrck, audio_sck and audio_sdin SHALL all be 0.
REQ-027 Reset mid-frame SHALL abort the frame; the first cycle after release is div_cnt=0 with a zero word serialized.
REQ-028 No output SHALL glitch or toggle during reset.

Structure
REQ-029 Shared package tone_pkg SHALL hold DIV_W=9, NOTE_W=22, SAMPLE_W=16, AMP_STEP=16'h1000 and the note_div constants for the note table (Low La 227272 ... High Si 50607).
REQ-030 Serialization and clock division SHALL be sub-module i2s_serializer (clk, rst, sample_l, sample_r -> four audio pins).
REQ-031 tone_synth SHALL hold the tone counter and amplitude logic.

Verification
REQ-032 rst 1 for 4 cycles, note_div=227272, vol=7 -> sq toggles every 227272 clk, first toggle 227272 cycles after release.
REQ-033 vol=7, sq=1 frame -> sdin shows 0111_0000_0000_0000 over 16 sck in both lrck halves; sq=0 frame -> 1001_0000_0000_0000.
REQ-034 Mid-period, with tone_cnt=150000, note_div changes 227272->95420 -> wrap and sq toggle on the next cycle, then period 95420.
REQ-035 note_div=1 or mute=1 or vol=0 -> all sdin bits 0 for the next full frame; mclk, sck and lrck keep running with periods 4, 16 and 512.
REQ-036 rst asserted at div_cnt=300 for 1 cycle -> all outputs 0 that cycle, restart at div_cnt=0, zero word framed.
